// File: rtl/lcr_pic.sv
// 8259-style vectored interrupt controller for the LCR580 CPU port bus.
// Optional `LCR_PIC_ROTATE_EN adds rotating priority via command bit7 on EOI.
module lcr_pic #(
  parameter int unsigned NUM_IRQ   = 8,
  parameter logic [7:0]  BASE_PORT = 8'h20,
  parameter int unsigned RST_BASE  = 0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ce,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [7:0]         port_addr,
  input  logic               port_we,
  input  logic               port_rd,
  input  logic [7:0]         port_wdata,
  output logic [7:0]         port_rdata,
  input  logic               iff1,
  input  logic               m0,
  input  logic               inta,
  output logic               int_req,
  output logic [7:0]         vec
);

  localparam logic [7:0] ImplMask = 8'((9'd1 << NUM_IRQ) - 9'd1);
  localparam logic [2:0] RstBase  = 3'(RST_BASE);
  localparam logic [7:0] PortCmd  = BASE_PORT;
  localparam logic [7:0] PortImr  = BASE_PORT + 8'd1;
  localparam logic [7:0] PortIsr  = BASE_PORT + 8'd2;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e     state_q, state_d;
  logic [7:0] sync1_q, sync2_q, hist_q;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] imr_q, imr_d;
  logic [7:0] vec_q, vec_d;
  logic       int_req_q, int_req_d;
  logic [2:0] prio_base;

  logic [7:0] irq_wide, edges, req, isr_eoi, ack_clear;
  logic [3:0] isr_first_old, req_first, isr_first;
  logic [2:0] req_rank, isr_rank, eoi_ch, rst_idx, cand_idx;
  logic       eoi_hit, eoi_valid, cand_valid, cmd_we, imr_we;

  // Returns {found, index} of the highest-priority set bit, base being highest.
  function automatic logic [3:0] find_first(input logic [7:0] v, input logic [2:0] base);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      idx = base + 3'(i);
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

`ifdef LCR_PIC_ROTATE_EN
  logic [2:0] prio_base_q, prio_base_d;
  assign prio_base = prio_base_q;

  always_comb begin
    prio_base_d = prio_base_q;
    if (eoi_hit && eoi_valid && port_wdata[7]) prio_base_d = eoi_ch + 3'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)  prio_base_q <= 3'd0;
    else if (ce)   prio_base_q <= prio_base_d;
  end
`else
  assign prio_base = 3'd0;
`endif

  always_comb begin
    irq_wide = '0;
    irq_wide[NUM_IRQ-1:0] = irq_in;
  end

  assign edges  = sync2_q & ~hist_q & ImplMask;
  assign cmd_we = port_we && (port_addr == PortCmd);
  assign imr_we = port_we && (port_addr == PortImr);

  // EOI resolution: applied before the candidate is evaluated this cycle.
  always_comb begin
    eoi_hit       = cmd_we && port_wdata[5];
    isr_first_old = find_first(isr_q, prio_base);
    if (port_wdata[6]) begin
      eoi_ch    = port_wdata[2:0];
      eoi_valid = ImplMask[port_wdata[2:0]];
    end else begin
      eoi_ch    = isr_first_old[2:0];
      eoi_valid = isr_first_old[3];
    end
    isr_eoi = isr_q;
    if (eoi_hit && eoi_valid) isr_eoi[eoi_ch] = 1'b0;
  end

  // Candidate must outrank every in-service channel in the current order.
  always_comb begin
    req        = irr_q & ~imr_q & ImplMask;
    req_first  = find_first(req, prio_base);
    isr_first  = find_first(isr_eoi, prio_base);
    req_rank   = req_first[2:0] - prio_base;
    isr_rank   = isr_first[2:0] - prio_base;
    cand_idx   = req_first[2:0];
    cand_valid = req_first[3] && (!isr_first[3] || (req_rank < isr_rank));
    rst_idx    = RstBase + cand_idx;
  end

  always_comb begin
    state_d   = state_q;
    isr_d     = isr_eoi;
    vec_d     = vec_q;
    ack_clear = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (inta) begin
          state_d = StHold;
          if (cand_valid) begin
            isr_d[cand_idx]     = 1'b1;
            ack_clear[cand_idx] = 1'b1;
            vec_d               = {2'b11, rst_idx, 3'b111};
          end else begin
            vec_d = 8'hFF;
          end
        end
      end
      StHold: begin
        if (!inta && m0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A fresh edge wins over the acknowledge clearing the same channel.
    irr_d     = ((irr_q & ~ack_clear) | edges) & ImplMask;
    imr_d     = imr_we ? (port_wdata | ~ImplMask) : imr_q;
    int_req_d = (state_d == StIdle) && iff1 && cand_valid;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      sync1_q   <= 8'h00;
      sync2_q   <= 8'h00;
      hist_q    <= 8'h00;
      irr_q     <= 8'h00;
      isr_q     <= 8'h00;
      imr_q     <= 8'hFF;
      vec_q     <= 8'hFF;
      int_req_q <= 1'b0;
    end else if (ce) begin
      state_q   <= state_d;
      sync1_q   <= irq_wide & ImplMask;
      sync2_q   <= sync1_q;
      hist_q    <= sync2_q;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      imr_q     <= imr_d;
      vec_q     <= vec_d;
      int_req_q <= int_req_d;
    end
  end

  always_comb begin
    port_rdata = 8'h00;
    if (port_rd) begin
      if (port_addr == PortCmd)      port_rdata = irr_q & ImplMask;
      else if (port_addr == PortImr) port_rdata = imr_q & ImplMask;
      else if (port_addr == PortIsr) port_rdata = isr_q & ImplMask;
    end
  end

  assign int_req = int_req_q;
  assign vec     = vec_q;

endmodule
